multimode_modulator: RTL and testbench

Parametrised digital modulator that turns a serial bit stream into offset-binary sine samples on clk_fast. It supports ASK, BPSK and BFSK, and generates its own symbol timing, so no divided clk_slow is needed. It accepts bits through a ready/valid handshake and emits one sample per clk_fast cycle. It sits between the bit source and the noise adder / DAC path, and replaces the fixed 8-bit, single-mode, clk_slow-driven modulator.

---
 rtl/modulator_pkg.sv | 29 ++
 rtl/sine_lut.sv | 65 ++++++
 rtl/multimode_modulator.sv | 209 ++++++++++++++++++++
 tb/tb_multimode_modulator.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/modulator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : modulator_pkg
// Description : Shared definitions for the multimode modulator: mode
//               encodings, FSM state encoding and the offset-binary
//               midscale helper.
// Revision    : 1.0 - initial release
// ============================================================================
package modulator_pkg;

  // Modulation mode encodings as seen on the mode input
  localparam logic [1:0] MODE_ASK  = 2'b00;
  localparam logic [1:0] MODE_BPSK = 2'b01;
  localparam logic [1:0] MODE_BFSK = 2'b10;
  localparam logic [1:0] MODE_OFF  = 2'b11;

  // Symbol FSM: IDLE waits for a bit, RUN emits SPS samples per bit
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Offset-binary midscale for a sample width: 2^(data_w-1)
  function automatic int unsigned midscale(input int unsigned data_w);
    return 32'd1 << (data_w - 32'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sine_lut.sv
`default_nettype none
// ============================================================================
// Module      : sine_lut
// Description : Full-period sine ROM with a registered output. Entry k is
//               MID + round((MID-1) * sin(2*pi*k / 2^LUT_AW)), so every
//               value lies in 1 .. 2^DATA_W-1. Contents are computed when
//               the design is elaborated.
// Ports       : clk_fast  - sample clock (rising edge)
//               rst       - asynchronous active-low reset
//               addr      - phase address, LUT_AW bits
//               data      - table value, valid one cycle after addr
// Revision    : 1.0 - initial release
// ============================================================================
module sine_lut
  import modulator_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LUT_AW = 6
) (
  input  logic              clk_fast,
  input  logic              rst,
  input  logic [LUT_AW-1:0] addr,
  output logic [DATA_W-1:0] data
);

  localparam int c_depth = 1 << LUT_AW;
  localparam int c_mid   = int'(midscale(DATA_W));

  // Symmetric round-half-away-from-zero keeps the table odd-symmetric
  // about midscale, which is what makes the BPSK inversion exact.
  function automatic logic [DATA_W-1:0] sine_entry(input int k);
    real v_ang;
    real v_amp;
    int  v_rnd;
    v_ang = 2.0 * 3.14159265358979323846 * real'(k) / real'(c_depth);
    v_amp = real'(c_mid - 1) * $sin(v_ang);
    if (v_amp >= 0.0) begin
      v_rnd = $rtoi(v_amp + 0.5);
    end else begin
      v_rnd = -$rtoi(0.5 - v_amp);
    end
    return DATA_W'(c_mid + v_rnd);
  endfunction

  logic [DATA_W-1:0] w_rom [c_depth];
  logic [DATA_W-1:0] r_data;

  generate
    for (genvar k = 0; k < c_depth; k++) begin : g_rom
      assign w_rom[k] = sine_entry(k);
    end
  endgenerate

  always_ff @(posedge clk_fast or negedge rst) begin
    if (!rst) begin
      r_data <= '0;
    end else begin
      r_data <= w_rom[addr];
    end
  end

  assign data = r_data;

endmodule
`default_nettype wire

// File: rtl/multimode_modulator.sv
`default_nettype none
// ============================================================================
// Module      : multimode_modulator
// Description : Serial-bit to offset-binary sine modulator (ASK / BPSK /
//               BFSK / silent). Bits arrive on a ready/valid handshake; each
//               accepted bit is expanded into SPS samples, one per clk_fast
//               cycle, with internally generated symbol timing.
// Ports       : clk_fast    - sample clock (rising edge)
//               rst         - asynchronous active-low reset
//               mode        - 00 ASK, 01 BPSK, 10 BFSK, 11 silent
//               step0/step1 - per-sample phase increments (bit 0 / bit 1)
//               s_valid     - input bit valid
//               s_bit       - input bit
//               s_ready     - a bit can be accepted this cycle
//               m_wav       - modulated sample (offset binary)
//               m_valid     - m_wav carries a symbol sample
//               sym_strobe  - m_wav is sample 0 of a symbol
// Revision    : 1.0 - initial release
// ============================================================================
module multimode_modulator
  import modulator_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LUT_AW = 6,
  parameter int SPS    = 16
) (
  input  logic              clk_fast,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic [LUT_AW-1:0] step0,
  input  logic [LUT_AW-1:0] step1,
  input  logic              s_valid,
  input  logic              s_bit,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_wav,
  output logic              m_valid,
  output logic              sym_strobe
);

  localparam int                c_cnt_w = $clog2(SPS);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(SPS - 1);
  localparam logic [DATA_W-1:0] c_mid   = DATA_W'(midscale(DATA_W));

  // --------------------------------------------------------------------------
  // Symbol FSM and handshake
  // --------------------------------------------------------------------------
  state_t             r_state;
  state_t             w_next_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic               w_ready;
  logic               w_accept;
  logic               w_last;

  // Symbol control latched at acceptance and held for the whole symbol
  logic               r_bit;
  logic [1:0]         r_mode;
  logic [LUT_AW-1:0]  r_step0;
  logic [LUT_AW-1:0]  r_step1;

  logic [LUT_AW-1:0]  r_phase;
  logic [LUT_AW-1:0]  w_step;

  always_comb begin
    w_next_state = r_state;
    w_ready      = 1'b0;
    w_last       = 1'b0;
    w_accept     = 1'b0;

    w_last   = (r_state == ST_RUN) && (r_cnt == c_last);
    // Ready on the final sample too, so symbols can run back to back
    w_ready  = (r_state == ST_IDLE) || (r_cnt == c_last);
    w_accept = s_valid && w_ready;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_last && !w_accept) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  assign s_ready = w_ready;

  always_ff @(posedge clk_fast or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Only a BFSK '1' uses step1; every other symbol advances by step0
  assign w_step = ((r_mode == MODE_BFSK) && r_bit) ? r_step1 : r_step0;

  always_ff @(posedge clk_fast or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_bit   <= 1'b0;
      r_mode  <= MODE_OFF;
      r_step0 <= '0;
      r_step1 <= '0;
      r_phase <= '0;
    end else begin
      if (w_accept) begin
        r_bit   <= s_bit;
        r_mode  <= mode;
        r_step0 <= step0;
        r_step1 <= step1;
        r_cnt   <= '0;
      end else if (r_state == ST_RUN) begin
        r_cnt <= w_last ? '0 : r_cnt + c_cnt_w'(1);
      end

      // The phase keeps running across a back-to-back boundary using the
      // outgoing symbol's step, so BFSK frequency changes stay continuous.
      // An underflow parks it at 0 so the next burst starts at phase 0.
      if (r_state == ST_RUN) begin
        r_phase <= (w_last && !w_accept) ? '0 : r_phase + w_step;
      end else begin
        r_phase <= '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1: phase address into the ROM plus the matching control sideband
  // --------------------------------------------------------------------------
  logic              r_s1_valid;
  logic              r_s1_strobe;
  logic              r_s1_bit;
  logic [1:0]        r_s1_mode;
  logic [DATA_W-1:0] w_lut;

  sine_lut #(
    .DATA_W (DATA_W),
    .LUT_AW (LUT_AW)
  ) u_sine_lut (
    .clk_fast (clk_fast),
    .rst      (rst),
    .addr     (r_phase),
    .data     (w_lut)
  );

  always_ff @(posedge clk_fast or negedge rst) begin
    if (!rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_strobe <= 1'b0;
      r_s1_bit    <= 1'b0;
      r_s1_mode   <= MODE_OFF;
    end else begin
      r_s1_valid  <= (r_state == ST_RUN);
      r_s1_strobe <= (r_state == ST_RUN) && (r_cnt == '0);
      r_s1_bit    <= r_bit;
      r_s1_mode   <= r_mode;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: map the table value by mode and register the outputs
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] w_lut_inv;
  logic [DATA_W-1:0] w_wav;
  logic [DATA_W-1:0] r_wav;
  logic              r_valid;
  logic              r_strobe;

  // 2*MID - s equals 2^DATA_W - s; with s >= 1 the DATA_W-bit wraparound
  // subtraction yields it exactly.
  assign w_lut_inv = '0 - w_lut;

  always_comb begin
    w_wav = c_mid;
    if (r_s1_valid) begin
      case (r_s1_mode)
        MODE_ASK:  w_wav = r_s1_bit ? w_lut : c_mid;
        MODE_BPSK: w_wav = r_s1_bit ? w_lut : w_lut_inv;
        MODE_BFSK: w_wav = w_lut;
        default:   w_wav = c_mid;
      endcase
    end
  end

  always_ff @(posedge clk_fast or negedge rst) begin
    if (!rst) begin
      r_wav    <= c_mid;
      r_valid  <= 1'b0;
      r_strobe <= 1'b0;
    end else begin
      r_wav    <= w_wav;
      r_valid  <= r_s1_valid;
      r_strobe <= r_s1_strobe;
    end
  end

  assign m_wav      = r_wav;
  assign m_valid    = r_valid;
  assign sym_strobe = r_strobe;

endmodule
`default_nettype wire

// File: tb/tb_multimode_modulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_multimode_modulator
// Description : Scoreboard bench for multimode_modulator. Stimulus pushes the
//               expected samples of every accepted bit (with the cycle they
//               are due); a negedge monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multimode_modulator;
  import modulator_pkg::*;

  localparam int DATA_W = 8;
  localparam int LUT_AW = 6;
  localparam int SPS    = 16;
  localparam int MID    = 128;
  localparam int DEPTH  = 64;

  logic              clk_fast = 1'b0;
  logic              rst      = 1'b0;
  logic [1:0]        mode     = 2'b00;
  logic [LUT_AW-1:0] step0    = '0;
  logic [LUT_AW-1:0] step1    = '0;
  logic              s_valid  = 1'b0;
  logic              s_bit    = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] m_wav;
  logic              m_valid;
  logic              sym_strobe;

  multimode_modulator #(
    .DATA_W (DATA_W),
    .LUT_AW (LUT_AW),
    .SPS    (SPS)
  ) dut (
    .clk_fast   (clk_fast),
    .rst        (rst),
    .mode       (mode),
    .step0      (step0),
    .step1      (step1),
    .s_valid    (s_valid),
    .s_bit      (s_bit),
    .s_ready    (s_ready),
    .m_wav      (m_wav),
    .m_valid    (m_valid),
    .sym_strobe (sym_strobe)
  );

  always #5 clk_fast = ~clk_fast;

  typedef struct {
    int due;
    int wav;
    int strobe;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   ncyc     = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state: is a symbol in flight, which sample, phase origin
  bit   m_busy   = 1'b0;
  int   m_cnt    = 0;
  int   m_start  = 0;
  int   m_step   = 0;

  always @(posedge clk_fast) ncyc <= ncyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, ncyc);
    end
  endtask

  function automatic int ref_sine(input int p);
    real v;
    v = real'(MID - 1) * $sin(2.0 * 3.141592653589793 * real'(p) / real'(DEPTH));
    if (v >= 0.0) return MID + $rtoi(v + 0.5);
    else          return MID - $rtoi(0.5 - v);
  endfunction

  function automatic int ref_sample(input int md, input int b, input int p);
    int s;
    s = ref_sine(p);
    case (md)
      0:       return (b != 0) ? s : MID;
      1:       return (b != 0) ? s : 2 * MID - s;
      2:       return s;
      default: return MID;
    endcase
  endfunction

  // One cycle of stimulus, driven at the negedge before the next rising edge.
  task automatic drive_cycle(input bit v, input bit b, input int md,
                             input int s0, input int s1, output bit acc);
    bit exp_ready;
    int start;
    int st;
    @(negedge clk_fast);
    exp_ready = !m_busy || (m_cnt == SPS - 1);
    check("s_ready", int'(s_ready), int'(exp_ready));
    s_valid = v;
    s_bit   = b;
    mode    = md[1:0];
    step0   = LUT_AW'(s0);
    step1   = LUT_AW'(s1);
    acc     = v && exp_ready;
    if (acc) begin
      start = m_busy ? (m_start + SPS * m_step) % DEPTH : 0;
      st    = (md == 2 && b) ? s1 : s0;
      for (int n = 0; n < SPS; n++) begin
        sbq.push_back('{ncyc + 3 + n, ref_sample(md, int'(b), (start + n * st) % DEPTH),
                        (n == 0) ? 1 : 0});
      end
      m_busy  = 1'b1;
      m_cnt   = 0;
      m_start = start;
      m_step  = st;
    end else if (m_busy) begin
      if (m_cnt == SPS - 1) m_busy = 1'b0;
      else                  m_cnt++;
    end
  endtask

  task automatic send(input bit b, input int md, input int s0, input int s1);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < SPS + 4 && !acc; i++) begin
      drive_cycle(1'b1, b, md, s0, s1, acc);
    end
    check("bit accepted", int'(acc), 1);
  endtask

  // Idle cycles keep scrambling mode/steps/bit to show they are latched
  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) begin
      drive_cycle(1'b0, 1'($urandom), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), acc);
    end
  endtask

  // Monitor: checks reset values, idle midscale and every scoreboard entry
  always @(negedge clk_fast) begin
    if (!rst) begin
      check("reset m_wav", int'(m_wav), MID);
      check("reset m_valid", int'(m_valid), 0);
      check("reset sym_strobe", int'(sym_strobe), 0);
      check("reset s_ready", int'(s_ready), 1);
    end else if (m_valid) begin
      check("sample expected", int'(sbq.size() != 0), 1);
      if (sbq.size() != 0) begin
        mon_e = sbq.pop_front();
        check("sample cycle", ncyc, mon_e.due);
        check("m_wav", int'(m_wav), mon_e.wav);
        check("sym_strobe", int'(sym_strobe), mon_e.strobe);
      end
    end else begin
      check("idle m_wav", int'(m_wav), MID);
      check("idle sym_strobe", int'(sym_strobe), 0);
      if (sbq.size() != 0 && sbq[0].due <= ncyc) begin
        check("m_valid for due sample", int'(m_valid), 1);
        void'(sbq.pop_front());
      end
    end
  end

  initial begin
    // Reset held with toggling inputs
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk_fast);
      s_valid = 1'($urandom);
      s_bit   = 1'($urandom);
      mode    = 2'($urandom);
      step0   = LUT_AW'($urandom);
      step1   = LUT_AW'($urandom);
    end
    @(negedge clk_fast);
    s_valid = 1'b0;
    rst     = 1'b1;

    // BPSK 1,0 back to back
    send(1'b1, 1, 4, 8);
    send(1'b0, 1, 4, 8);
    idle(20);

    // ASK 0,1
    send(1'b0, 0, 4, 8);
    send(1'b1, 0, 4, 8);
    idle(20);

    // BFSK 1,0: phase continuity across the frequency change
    send(1'b1, 2, 4, 8);
    send(1'b0, 2, 4, 8);
    idle(20);

    // Underflow, then a fresh bit restarting at phase 0
    send(1'b1, 1, 4, 8);
    idle(20);
    send(1'b1, 1, 4, 8);
    idle(20);

    // Asynchronous reset in the middle of a BPSK symbol
    send(1'b1, 1, 4, 8);
    idle(8);
    @(negedge clk_fast);
    #2 rst = 1'b0;
    #1;
    check("async rst m_wav", int'(m_wav), MID);
    check("async rst m_valid", int'(m_valid), 0);
    check("async rst sym_strobe", int'(sym_strobe), 0);
    check("async rst s_ready", int'(s_ready), 1);
    sbq.delete();
    m_busy = 1'b0;
    m_cnt  = 0;
    s_valid = 1'b0;
    repeat (3) @(negedge clk_fast);
    rst = 1'b1;

    // Silent mode still produces a valid symbol of midscale samples
    send(1'b1, 3, 4, 8);
    idle(20);

    // Randomised traffic: random modes, bits, steps and gaps
    repeat (40) begin
      if ($urandom_range(0, 3) == 0) begin
        idle(int'($urandom_range(1, 20)));
      end else begin
        send(1'($urandom), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
      end
    end

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 3 * SPS && sbq.size() != 0; i++) idle(1);
    idle(3);
    check("scoreboard drained", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
